// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_pkg
// Purpose  : Shared definitions for the DRAM request arbiter. Holds the
//            arbiter FSM state encoding, the default DRAM widths, the default
//            watchdog limit and a one-hot to index helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dram_pkg;

    localparam int DEFAULT_ADDR_WIDTH     = 32;
    localparam int DEFAULT_DATA_WIDTH     = 512;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam int LEN_WIDTH              = 8;

    // The requester count is capped at 4, so a 2-bit index covers every
    // legal configuration.
    localparam int MAX_REQ   = 4;
    localparam int REQ_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESPOND    = 3'd4
    } arb_state_t;

    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = REQ_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_request_arbiter_if
// Purpose  : Requester-side command/response bus of the DRAM request arbiter.
// Ports    : master - requester side: drives req_valid/req_write/req_addr/
//                     req_len/req_wdata, receives req_ready/rsp_done/
//                     rsp_err/rsp_rdata.
//            slave  - arbiter side, directions reversed.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_request_arbiter_if
    import dram_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int AXI_ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DRAM_DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_write;
    logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]       req_len;
    logic [NUM_REQ*DRAM_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 rsp_done;
    logic                               rsp_err;
    logic [DRAM_DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        input  req_ready, rsp_done, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        output req_ready, rsp_done, rsp_err, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant. The search starts at
//            (last_grant + 1) mod NUM_REQ and the first pending request wins.
// Ports    : req        in  NUM_REQ   pending request vector
//            last_grant in  REQ_IDX_W index of the previously served requester
//            grant      out NUM_REQ   one-hot grant (all zero if no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dram_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] last_grant,
    output logic [NUM_REQ-1:0]   grant
);
    logic w_found;

    // Outer loop walks priority positions; inner loop only compares so every
    // bit select uses a loop constant.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req[k] &&
                    (k == ((int'(last_grant) + off) % NUM_REQ))) begin
                    grant[k] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_request_arbiter
// Purpose  : Serialises commands from NUM_REQ requesters onto a single-issue
//            DRAM controller port, round-robin, with a per-transaction
//            watchdog.
// Ports    : m_axi_aclk / m_axi_aresetn   clock, async active-low reset
//            req_bus (slave)               requester commands and responses
//            dram_read_*  / dram_write_*   command outputs to DRAM controller
//            dram_read_data(_valid), dram_read_busy, dram_write_busy
//                                          status inputs from DRAM controller
// Revision : 1.0 - initial release
// ============================================================================
module dram_request_arbiter
    import dram_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DRAM_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ         = 2,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       m_axi_aclk,
    input  logic                       m_axi_aresetn,
    dram_request_arbiter_if.slave      req_bus,
    output logic [AXI_ADDR_WIDTH-1:0]  dram_read_addr,
    output logic [LEN_WIDTH-1:0]       dram_read_len,
    output logic                       dram_read_en,
    output logic [AXI_ADDR_WIDTH-1:0]  dram_write_addr,
    output logic [LEN_WIDTH-1:0]       dram_write_len,
    output logic                       dram_write_en,
    output logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    input  logic                       dram_read_data_valid,
    input  logic                       dram_read_busy,
    input  logic                       dram_write_busy
);
    localparam int                c_WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                 r_state;
    logic [REQ_IDX_W-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]         r_owner;
    logic                       r_is_write;
    logic [c_WD_W-1:0]          r_wdog;
    logic [NUM_REQ-1:0]         r_req_ready;
    logic [NUM_REQ-1:0]         r_rsp_done;
    logic                       r_rsp_err;
    logic [DRAM_DATA_WIDTH-1:0] r_rsp_rdata;

    logic [NUM_REQ-1:0]         w_grant;
    logic                       w_sel_write;
    logic [AXI_ADDR_WIDTH-1:0]  w_sel_addr;
    logic [LEN_WIDTH-1:0]       w_sel_len;
    logic [DRAM_DATA_WIDTH-1:0] w_sel_wdata;
    logic                       w_busy;
    logic                       w_timeout;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // One-hot mux of the granted requester's command fields.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_write = req_bus.req_write[i];
                w_sel_addr  = req_bus.req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                w_sel_len   = req_bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
                w_sel_wdata = req_bus.req_wdata[i*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH];
            end
        end
    end

    assign w_busy    = r_is_write ? dram_write_busy : dram_read_busy;
    assign w_timeout = (r_wdog == c_WD_LIMIT);

    assign req_bus.req_ready = r_req_ready;
    assign req_bus.rsp_done  = r_rsp_done;
    assign req_bus.rsp_err   = r_rsp_err;
    assign req_bus.rsp_rdata = r_rsp_rdata;

    // All outputs are registered: req_ready and dram_*_en are set on the
    // IDLE->ISSUE edge so they are high for exactly the ISSUE cycle, and
    // rsp_done is set on entry to RESPOND so it is high for that cycle.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= REQ_IDX_W'(NUM_REQ - 1);
            r_owner         <= '0;
            r_is_write      <= 1'b0;
            r_wdog          <= '0;
            r_req_ready     <= '0;
            r_rsp_done      <= '0;
            r_rsp_err       <= 1'b0;
            r_rsp_rdata     <= '0;
            dram_read_addr  <= '0;
            dram_read_len   <= '0;
            dram_read_en    <= 1'b0;
            dram_write_addr <= '0;
            dram_write_len  <= '0;
            dram_write_en   <= 1'b0;
            dram_write_data <= '0;
        end else begin
            r_req_ready   <= '0;
            r_rsp_done    <= '0;
            dram_read_en  <= 1'b0;
            dram_write_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_owner     <= w_grant;
                        r_is_write  <= w_sel_write;
                        r_req_ready <= w_grant;
                        // Only the port being used is updated; the other
                        // keeps its last command.
                        if (w_sel_write) begin
                            dram_write_en   <= 1'b1;
                            dram_write_addr <= w_sel_addr;
                            dram_write_len  <= w_sel_len;
                            dram_write_data <= w_sel_wdata;
                        end else begin
                            dram_read_en    <= 1'b1;
                            dram_read_addr  <= w_sel_addr;
                            dram_read_len   <= w_sel_len;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_busy) begin
                        r_wdog  <= r_wdog + 1'b1;
                        r_state <= ST_WAIT_DONE;
                    end else if (w_timeout) begin
                        r_rsp_done <= r_owner;
                        r_rsp_err  <= 1'b1;
                        r_state    <= ST_RESPOND;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!w_busy) begin
                        r_rsp_done <= r_owner;
                        if (r_is_write) begin
                            r_rsp_err <= 1'b0;
                        end else begin
                            r_rsp_rdata <= dram_read_data;
                            r_rsp_err   <= ~dram_read_data_valid;
                        end
                        r_state <= ST_RESPOND;
                    end else if (w_timeout) begin
                        r_rsp_done <= r_owner;
                        r_rsp_err  <= 1'b1;
                        r_state    <= ST_RESPOND;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    r_last_grant <= onehot_to_idx(MAX_REQ'(r_owner));
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
